// File: rtl/dram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM (port A writes, port B reads
// with a 1-cycle registered read). Tracks pointers, occupancy and sticky error flags.
module dram_fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int ADDR     = 6,
    parameter int AF_LEVEL = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow,
    output logic             ram_ena,
    output logic             ram_wra,
    output logic             ram_enb,
    output logic             ram_wrb,
    output logic [WIDTH-1:0] ram_din_a,
    output logic [ADDR-1:0]  ram_addr_a,
    output logic [ADDR-1:0]  ram_addr_b,
    input  logic [WIDTH-1:0] ram_dout_b
);

    localparam logic [ADDR:0] DEPTH  = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0] AF_CNT = (ADDR+1)'(AF_LEVEL);

    logic [ADDR-1:0] wptr_reg;
    logic [ADDR-1:0] rptr_reg;
    logic [ADDR:0]   count_reg;
    logic            rd_valid_reg;
    logic            overflow_reg;
    logic            underflow_reg;
    logic            wr_acc;
    logic            rd_acc;

    assign full        = (count_reg == DEPTH);
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= AF_CNT);

    // Flags come from the registered count, so a read and a write can never
    // target the same address in one cycle and there is no fall-through.
    assign wr_acc = !rst && wr_en && !full;
    assign rd_acc = !rst && rd_en && !empty;

    assign ram_ena    = wr_acc;
    assign ram_wra    = 1'b1;
    assign ram_addr_a = wptr_reg;
    assign ram_din_a  = din;
    assign ram_enb    = rd_acc;
    assign ram_wrb    = 1'b0;
    assign ram_addr_b = rptr_reg;

    assign rd_data   = ram_dout_b;
    assign rd_valid  = rd_valid_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) wptr_reg <= wptr_reg + ADDR'(1);
            if (rd_acc) rptr_reg <= rptr_reg + ADDR'(1);
            if (wr_acc && !rd_acc)
                count_reg <= count_reg + (ADDR+1)'(1);
            else if (rd_acc && !wr_acc)
                count_reg <= count_reg - (ADDR+1)'(1);
            rd_valid_reg  <= rd_acc;
            // A new error in the same cycle as clr_err wins.
            overflow_reg  <= (overflow_reg && !clr_err) || (wr_en && full);
            underflow_reg <= (underflow_reg && !clr_err) || (rd_en && empty);
        end
    end

endmodule
